regfile_op_sequencer: RTL and testbench

Multi-cycle controller that sequences the 4-entry x 4-bit register file (2 combinational read ports, 1 clocked write port with enable). It accepts one micro-op per valid/ready handshake, drives the register file read/write ports, computes the result, and writes it back. After reset it clears all four registers before accepting commands.

---
 rtl/regfile_op_sequencer_pkg.sv | 26 ++
 rtl/regfile_op_sequencer_alu_4.sv | 48 ++++
 rtl/regfile_op_sequencer.sv | 155 +++++++++++++++
 tb/tb_regfile_op_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_op_sequencer_pkg.sv
// Shared types and constants for the register-file micro-op sequencer.
// Contents:
//   REG_ADDR_W, DATA_W, NUM_REGS : register file geometry (4 x 4-bit)
//   opcode_t                     : micro-op encoding (LDI, ADD, SUB, MOV)
//   state_t                      : sequencer FSM states
package regfile_op_sequencer_pkg;

  localparam int REG_ADDR_W = 2;
  localparam int DATA_W     = 4;
  localparam int NUM_REGS   = 4;

  typedef enum logic [1:0] {
    OP_LDI = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_MOV = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    INIT  = 2'b00,
    IDLE  = 2'b01,
    EXEC  = 2'b10,
    WRITE = 2'b11
  } state_t;

endpackage

// File: rtl/regfile_op_sequencer_alu_4.sv
// Combinational 4-bit ALU used in the EXEC cycle of the sequencer.
// Ports:
//   op_i    : micro-op to evaluate
//   a_i     : operand from read port 0
//   b_i     : operand from read port 1
//   imm_i   : immediate for LDI
//   res_o   : 4-bit result
//   carry_o : ADD carry-out, SUB borrow, 0 for LDI/MOV
module alu_4
  import regfile_op_sequencer_pkg::*;
(
  input  opcode_t           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] res_o,
  output logic              carry_o
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // Both arithmetic paths are one bit wider; for SUB the extra bit of the
  // wrapped difference is exactly the borrow (a < b).
  always_comb begin
    sum     = {1'b0, a_i} + {1'b0, b_i};
    diff    = {1'b0, a_i} - {1'b0, b_i};
    res_o   = a_i;
    carry_o = 1'b0;
    case (op_i)
      OP_LDI: res_o = imm_i;
      OP_ADD: begin
        res_o   = sum[DATA_W-1:0];
        carry_o = sum[DATA_W];
      end
      OP_SUB: begin
        res_o   = diff[DATA_W-1:0];
        carry_o = diff[DATA_W];
      end
      OP_MOV: res_o = a_i;
      default: begin
        res_o   = a_i;
        carry_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Multi-cycle controller for a 4 x 4-bit register file (2 async read ports,
// 1 clocked write port). After reset it optionally clears every register,
// then accepts one micro-op per valid/ready handshake: IDLE (accept) ->
// EXEC (read operands, compute) -> WRITE (write back, o_done pulse).
// Ports:
//   i_clk, i_rst_n              : clock, synchronous active-low reset
//   i_cmd_valid / o_cmd_ready   : command handshake
//   i_cmd_op/rd/rs0/rs1/imm     : command fields, sampled at the accept edge
//   o_reg_read_0/1, i_port_read_0/1 : register file read ports
//   o_reg_write, o_port_write, o_write_enable : register file write port
//   o_done, o_result, o_carry   : completion pulse and registered result
module regfile_op_sequencer
  import regfile_op_sequencer_pkg::*;
#(
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE     = 4'h0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [1:0]            i_cmd_op,
  input  logic [REG_ADDR_W-1:0] i_cmd_rd,
  input  logic [REG_ADDR_W-1:0] i_cmd_rs0,
  input  logic [REG_ADDR_W-1:0] i_cmd_rs1,
  input  logic [DATA_W-1:0]     i_cmd_imm,
  output logic [REG_ADDR_W-1:0] o_reg_read_0,
  output logic [REG_ADDR_W-1:0] o_reg_read_1,
  input  logic [DATA_W-1:0]     i_port_read_0,
  input  logic [DATA_W-1:0]     i_port_read_1,
  output logic [REG_ADDR_W-1:0] o_reg_write,
  output logic [DATA_W-1:0]     o_port_write,
  output logic                  o_write_enable,
  output logic                  o_done,
  output logic [DATA_W-1:0]     o_result,
  output logic                  o_carry
);

  state_t                state_q, state_d;
  logic [REG_ADDR_W-1:0] cnt_q, cnt_d;
  opcode_t               op_q, op_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [REG_ADDR_W-1:0] rs0_q, rs0_d;
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
  logic [DATA_W-1:0]     imm_q, imm_d;
  logic [DATA_W-1:0]     result_q, result_d;
  logic                  carry_q, carry_d;

  logic [DATA_W-1:0]     aluRes;
  logic                  aluCarry;
  logic                  writeReq;
  logic [REG_ADDR_W-1:0] writeAddr;
  logic [DATA_W-1:0]     writeData;
  logic                  cmdReady;
  logic                  donePulse;

  alu_4 u_alu (
    .op_i    (op_q),
    .a_i     (i_port_read_0),
    .b_i     (i_port_read_1),
    .imm_i   (imm_q),
    .res_o   (aluRes),
    .carry_o (aluCarry)
  );

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      if (CLEAR_ON_RESET) state_q <= INIT;
      else                state_q <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_LDI;
      rd_q     <= '0;
      rs0_q    <= '0;
      rs1_q    <= '0;
      imm_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs0_q    <= rs0_d;
      rs1_q    <= rs1_d;
      imm_q    <= imm_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  // Next-state and port control. The init counter wraps back to 0 after
  // the last clear write, so it is ready for the next reset without help.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rs0_d     = rs0_q;
    rs1_d     = rs1_q;
    imm_d     = imm_q;
    result_d  = result_q;
    carry_d   = carry_q;
    writeReq  = 1'b0;
    writeAddr = rd_q;
    writeData = result_q;
    cmdReady  = 1'b0;
    donePulse = 1'b0;
    case (state_q)
      INIT: begin
        writeReq  = 1'b1;
        writeAddr = cnt_q;
        writeData = INIT_VALUE;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == REG_ADDR_W'(NUM_REGS - 1)) state_d = IDLE;
      end
      IDLE: begin
        cmdReady = 1'b1;
        if (i_cmd_valid) begin
          op_d    = opcode_t'(i_cmd_op);
          rd_d    = i_cmd_rd;
          rs0_d   = i_cmd_rs0;
          rs1_d   = i_cmd_rs1;
          imm_d   = i_cmd_imm;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = aluRes;
        carry_d  = aluCarry;
        state_d  = WRITE;
      end
      WRITE: begin
        writeReq  = 1'b1;
        donePulse = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read addresses come straight from the latched source fields, so they
  // are valid in EXEC and hold their last value elsewhere. The write enable
  // is masked by reset so no write escapes during a reset cycle.
  assign o_reg_read_0   = rs0_q;
  assign o_reg_read_1   = rs1_q;
  assign o_reg_write    = writeAddr;
  assign o_port_write   = writeData;
  assign o_write_enable = writeReq & i_rst_n;
  assign o_cmd_ready    = cmdReady;
  assign o_done         = donePulse;
  assign o_result       = result_q;
  assign o_carry        = carry_q;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Self-checking bench for regfile_op_sequencer. A behavioural register
// file is attached to the main instance; a second instance with
// CLEAR_ON_RESET=0 checks the no-clear start-up path. Expected results are
// computed from a golden register array when a command is driven and
// queued, then popped when o_done fires.
module tb_regfile_op_sequencer;

  typedef struct {
    logic [1:0] rd;
    logic [3:0] res;
    logic       carry;
  } expItem_t;

  logic       clk;
  logic       rstN;
  logic       cmdValid;
  logic [1:0] cmdOp;
  logic [1:0] cmdRd;
  logic [1:0] cmdRs0;
  logic [1:0] cmdRs1;
  logic [3:0] cmdImm;

  logic       dutReady;
  logic [1:0] dutRaddr0;
  logic [1:0] dutRaddr1;
  logic [3:0] portRead0;
  logic [3:0] portRead1;
  logic [1:0] dutWaddr;
  logic [3:0] dutWdata;
  logic       dutWe;
  logic       dutDone;
  logic [3:0] dutResult;
  logic       dutCarry;

  logic       plainReady;
  logic [1:0] plainRaddr0;
  logic [1:0] plainRaddr1;
  logic [1:0] plainWaddr;
  logic [3:0] plainWdata;
  logic       plainWe;
  logic       plainDone;
  logic [3:0] plainResult;
  logic       plainCarry;

  logic [3:0] tbRegs     [4];
  logic [3:0] goldenRegs [4];
  expItem_t   sbQueue    [$];

  int testCount = 0;
  int failCount = 0;

  regfile_op_sequencer #(.CLEAR_ON_RESET(1'b1), .INIT_VALUE(4'h0)) u_dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_cmd_valid    (cmdValid),
    .o_cmd_ready    (dutReady),
    .i_cmd_op       (cmdOp),
    .i_cmd_rd       (cmdRd),
    .i_cmd_rs0      (cmdRs0),
    .i_cmd_rs1      (cmdRs1),
    .i_cmd_imm      (cmdImm),
    .o_reg_read_0   (dutRaddr0),
    .o_reg_read_1   (dutRaddr1),
    .i_port_read_0  (portRead0),
    .i_port_read_1  (portRead1),
    .o_reg_write    (dutWaddr),
    .o_port_write   (dutWdata),
    .o_write_enable (dutWe),
    .o_done         (dutDone),
    .o_result       (dutResult),
    .o_carry        (dutCarry)
  );

  regfile_op_sequencer #(.CLEAR_ON_RESET(1'b0), .INIT_VALUE(4'h0)) u_plain (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_cmd_valid    (1'b0),
    .o_cmd_ready    (plainReady),
    .i_cmd_op       (cmdOp),
    .i_cmd_rd       (cmdRd),
    .i_cmd_rs0      (cmdRs0),
    .i_cmd_rs1      (cmdRs1),
    .i_cmd_imm      (cmdImm),
    .o_reg_read_0   (plainRaddr0),
    .o_reg_read_1   (plainRaddr1),
    .i_port_read_0  (4'h0),
    .i_port_read_1  (4'h0),
    .o_reg_write    (plainWaddr),
    .o_port_write   (plainWdata),
    .o_write_enable (plainWe),
    .o_done         (plainDone),
    .o_result       (plainResult),
    .o_carry        (plainCarry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file: asynchronous reads, write on the rising edge.
  assign portRead0 = tbRegs[dutRaddr0];
  assign portRead1 = tbRegs[dutRaddr1];
  always @(posedge clk) begin
    if (dutWe) tbRegs[dutWaddr] <= dutWdata;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic computeExpected(input logic [1:0] op, input logic [1:0] rs0,
                                 input logic [1:0] rs1, input logic [3:0] imm,
                                 output logic [3:0] res, output logic carry);
    int a, b, t;
    a = int'(goldenRegs[rs0]);
    b = int'(goldenRegs[rs1]);
    res = 4'h0;
    carry = 1'b0;
    case (op)
      2'b00: res = imm;
      2'b01: begin
        t = a + b;
        res = 4'(t % 16);
        carry = (t > 15);
      end
      2'b10: begin
        t = a - b;
        res = 4'((t + 16) % 16);
        carry = (t < 0);
      end
      default: res = 4'(a);
    endcase
  endtask

  // Drives the command fields and records the expected write-back.
  task automatic driveCmd(input logic [1:0] op, input logic [1:0] rd,
                          input logic [1:0] rs0, input logic [1:0] rs1,
                          input logic [3:0] imm);
    expItem_t item;
    cmdOp = op;
    cmdRd = rd;
    cmdRs0 = rs0;
    cmdRs1 = rs1;
    cmdImm = imm;
    cmdValid = 1'b1;
    item.rd = rd;
    computeExpected(op, rs0, rs1, imm, item.res, item.carry);
    sbQueue.push_back(item);
    goldenRegs[rd] = item.res;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] rd,
                               input logic [1:0] rs0, input logic [1:0] rs1,
                               input logic [3:0] imm, input bit holdValid);
    int n;
    n = 0;
    while (!dutReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmdReadyWait", dutReady, 1);
    driveCmd(op, rd, rs0, rs1, imm);
    if (!holdValid) begin
      @(posedge clk);
      #1 cmdValid = 1'b0;
    end
  endtask

  task automatic waitDone(output int cycles);
    expItem_t item;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!dutDone && cycles < 10);
    checkOutput("doneSeen", dutDone, 1);
    checkOutput("sbNotEmpty", sbQueue.size() != 0, 1);
    if (dutDone && sbQueue.size() != 0) begin
      item = sbQueue.pop_front();
      checkOutput("doneResult", dutResult, item.res);
      checkOutput("doneCarry", dutCarry, item.carry);
      checkOutput("doneWe", dutWe, 1);
      checkOutput("doneWaddr", dutWaddr, item.rd);
      checkOutput("doneWdata", dutWdata, item.res);
    end
  endtask

  // Entered just after reset release: four clear writes, then ready.
  task automatic checkInitSequence(input bit checkPlain);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("initWe", dutWe, 1);
      checkOutput("initWaddr", dutWaddr, i[1:0]);
      checkOutput("initWdata", dutWdata, 4'h0);
      checkOutput("initReady", dutReady, 0);
      if (checkPlain) begin
        checkOutput("plainNoInitWe", plainWe, 0);
        if (i == 0) checkOutput("plainReadyFirst", plainReady, 1);
      end
    end
    @(negedge clk);
    checkOutput("initReadyRise", dutReady, 1);
    for (int i = 0; i < 4; i++) begin
      goldenRegs[i] = 4'h0;
      checkOutput("regCleared", tbRegs[i], goldenRegs[i]);
    end
  endtask

  task automatic checkRegs();
    for (int i = 0; i < 4; i++) checkOutput("regContents", tbRegs[i], goldenRegs[i]);
  endtask

  initial begin
    int c1;
    int c2;
    for (int i = 0; i < 4; i++) begin
      tbRegs[i] = 4'h5;
      goldenRegs[i] = 4'h5;
    end
    rstN = 1'b0;
    cmdValid = 1'b0;
    cmdOp = 2'b00;
    cmdRd = 2'b00;
    cmdRs0 = 2'b00;
    cmdRs1 = 2'b00;
    cmdImm = 4'h0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rstReady", dutReady, 0);
    checkOutput("rstWe", dutWe, 0);
    checkOutput("rstDone", dutDone, 0);
    checkOutput("rstResult", dutResult, 4'h0);
    checkOutput("rstCarry", dutCarry, 0);
    @(posedge clk);
    #1 rstN = 1'b1;
    checkInitSequence(1'b1);

    // LDI R2 = A with exact timing.
    applyStimulus(2'b00, 2'd2, 2'd3, 2'd1, 4'hA, 1'b0);
    @(negedge clk);
    checkOutput("execReady", dutReady, 0);
    checkOutput("execRaddr0", dutRaddr0, 2'd3);
    checkOutput("execRaddr1", dutRaddr1, 2'd1);
    checkOutput("execWe", dutWe, 0);
    waitDone(c1);
    checkOutput("ldiLatency", c1[7:0], 8'd1);
    @(negedge clk);
    checkOutput("postReady", dutReady, 1);
    checkOutput("postDone", dutDone, 0);
    checkOutput("postResultHeld", dutResult, 4'hA);
    checkRegs();

    // Arithmetic with carry and borrow.
    applyStimulus(2'b00, 2'd1, 2'd0, 2'd0, 4'h9, 1'b0);
    waitDone(c1);
    applyStimulus(2'b00, 2'd2, 2'd0, 2'd0, 4'h8, 1'b0);
    waitDone(c1);
    applyStimulus(2'b01, 2'd3, 2'd1, 2'd2, 4'h0, 1'b0);
    waitDone(c1);
    checkOutput("addLatency", c1[7:0], 8'd2);
    applyStimulus(2'b10, 2'd0, 2'd2, 2'd1, 4'h0, 1'b0);
    waitDone(c1);
    applyStimulus(2'b10, 2'd0, 2'd1, 2'd2, 4'h0, 1'b0);
    waitDone(c1);
    applyStimulus(2'b11, 2'd3, 2'd2, 2'd0, 4'hF, 1'b0);
    waitDone(c1);
    applyStimulus(2'b01, 2'd2, 2'd2, 2'd0, 4'h0, 1'b0);
    waitDone(c1);
    @(negedge clk);
    checkRegs();

    // Back-to-back with valid held high; second command depends on the first.
    applyStimulus(2'b00, 2'd1, 2'd0, 2'd0, 4'h5, 1'b1);
    @(negedge clk);
    checkOutput("b2bExecReady", dutReady, 0);
    driveCmd(2'b01, 2'd1, 2'd1, 2'd1, 4'h0);
    waitDone(c1);
    checkOutput("b2bWriteReady", dutReady, 0);
    @(negedge clk);
    checkOutput("b2bIdleReady", dutReady, 1);
    @(posedge clk);
    #1 cmdValid = 1'b0;
    waitDone(c2);
    checkOutput("b2bSpacing", 8'(1 + c2), 8'd3);
    @(negedge clk);
    checkRegs();

    // Reset during EXEC of ADD rd=3 aborts the write.
    applyStimulus(2'b00, 2'd3, 2'd0, 2'd0, 4'h7, 1'b0);
    waitDone(c1);
    @(negedge clk);
    cmdOp = 2'b01;
    cmdRd = 2'd3;
    cmdRs0 = 2'd1;
    cmdRs1 = 2'd1;
    cmdValid = 1'b1;
    @(posedge clk);
    #1 cmdValid = 1'b0;
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("abortR3", tbRegs[3], goldenRegs[3]);
    checkOutput("abortWe", dutWe, 0);
    checkOutput("abortDone", dutDone, 0);
    checkOutput("abortResult", dutResult, 4'h0);
    checkOutput("abortCarry", dutCarry, 0);
    @(posedge clk);
    #1 rstN = 1'b1;
    checkInitSequence(1'b0);

    // One more command after the second clear.
    applyStimulus(2'b00, 2'd0, 2'd0, 2'd0, 4'h3, 1'b0);
    waitDone(c1);
    applyStimulus(2'b10, 2'd1, 2'd1, 2'd0, 4'h0, 1'b0);
    waitDone(c1);
    @(negedge clk);
    checkRegs();
    checkOutput("sbDrained", sbQueue.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
